// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS controller.
//   - opcode constants for the instruction classes the controller sequences
//   - FSM state enum (encodings are visible on state_dbg, so they are fixed)
//   - alu_op, pc_source and alu_src_b select encodings
//   - is_mem_state(): states that hold a memory strobe and wait on mem_ready
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_ALU_WB   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11,
        ST_FAULT    = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;  // PC+4 straight from the ALU
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;  // branch target held in ALU out
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// mips_ctrl_wait_timer: counts consecutive cycles a memory access is stalled.
//   clk, rst  - clock, synchronous active-high reset
//   waiting   - in a memory state with mem_ready low this cycle
//   timeout   - this is the TIMEOUT_CYCLES-th consecutive stalled cycle
// Any cycle that is not a stall clears the count, so each new memory access
// starts from zero. TIMEOUT_CYCLES must be at least 1.
module mips_ctrl_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Compare against TIMEOUT_CYCLES-1 so the fault is raised on the stalled
    // cycle itself rather than one cycle later.
    assign timeout = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !waiting) begin
            cnt <= '0;
        end else if (!timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing a multicycle MIPS datapath.
//   Inputs : clk, rst (sync, active-high), opcode, funct (unused here),
//            mem_ready (memory access done this cycle).
//   Outputs: PC/IR enables, memory strobes, register-bank flags, mux and
//            ALU selects, sticky fault, retired-instruction count, state_dbg.
// Outputs decode the state register only; ir_write and pc_write in FETCH
// also look at mem_ready so the fetched word is captured on completion.
// Build option MIPS_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap to FAULT and
// raise the sticky 'illegal' output instead of retiring as a NOP.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                read_reg_flag,
    output logic                write_reg_flag,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                fault,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_dbg
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    state_t state, next_state;
    logic   waiting, timeout, retire_ev;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic   illegal_op;
`endif

    // funct is decoded by the ALU control, not here.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign waiting   = is_mem_state(state) && !mem_ready;
    assign state_dbg = state;

    mips_ctrl_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .waiting(waiting),
        .timeout(timeout)
    );

    // Next-state and retire decision.
    always_comb begin
        next_state = state;
        retire_ev  = 1'b0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                if (timeout)        next_state = ST_FAULT;
                else if (mem_ready) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = ST_EXEC_R;
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    OP_ADDI:      next_state = ST_ADDI_EX;
                    default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        next_state = ST_FAULT;
                        illegal_op = 1'b1;
`else
                        next_state = ST_FETCH;
                        retire_ev  = 1'b1;
`endif
                    end
                endcase
            end
            ST_MEM_ADDR: next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (timeout)        next_state = ST_FAULT;
                else if (mem_ready) next_state = ST_MEM_WB;
            end
            ST_MEM_WR: begin
                if (timeout) begin
                    next_state = ST_FAULT;
                end else if (mem_ready) begin
                    next_state = ST_FETCH;
                    retire_ev  = 1'b1;
                end
            end
            ST_EXEC_R:  next_state = ST_ALU_WB;
            ST_ADDI_EX: next_state = ST_ADDI_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: begin
                next_state = ST_FETCH;
                retire_ev  = 1'b1;
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_FETCH;  // unused encodings recover
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            retired <= '0;
            fault   <= 1'b0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            illegal <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (retire_ev) retired <= retired + RETIRE_W'(1);
            if (timeout)   fault   <= 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            if (illegal_op) begin
                fault   <= 1'b1;
                illegal <= 1'b1;
            end
`endif
        end
    end

    // Moore output decode; unlisted signals are 0 in every state.
    always_comb begin
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        pc_source      = PCSRC_ALU;
        ir_write       = 1'b0;
        iord           = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        read_reg_flag  = 1'b0;
        write_reg_flag = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_REG;
        alu_op         = ALU_ADD;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                read_reg_flag = 1'b1;
                alu_src_b     = SRCB_IMM_SH;
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                write_reg_flag = 1'b1;
                mem_to_reg     = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_ALU_WB: begin
                write_reg_flag = 1'b1;
                reg_dst        = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: write_reg_flag = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: self-checking bench for mips_multicycle_ctrl.
// Each instruction is expanded into the list of states it must visit (from
// its class and the memory stall lengths), queued, and replayed cycle by
// cycle against state_dbg and the full control word.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic        read_reg_flag, write_reg_flag, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic        fault;
    logic [31:0] retired;
    logic [3:0]  state_dbg;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_retired = 32'd0;
    logic [3:0]  exp_q[$];
    logic        rdy_q[$];
    logic [16:0] obs;

    assign obs = {pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
                  mem_write, read_reg_flag, write_reg_flag, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op};

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .read_reg_flag(read_reg_flag), .write_reg_flag(write_reg_flag),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .fault(fault),
        .retired(retired), .state_dbg(state_dbg)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Control word each state must present, straight from the state table:
    // {pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
    //  read_reg_flag, write_reg_flag, reg_dst, mem_to_reg, alu_src_a,
    //  alu_src_b, alu_op}
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
        logic pw = 0, pwc = 0, irw = 0, io = 0, mr = 0, mw = 0, rr = 0, wr = 0;
        logic rd = 0, m2r = 0, sa = 0;
        logic [1:0] ps = 0, sb = 0, op = 0;
        case (st)
            0:  begin mr = 1; sb = 2'd1; pw = rdy; irw = rdy; end
            1:  begin rr = 1; sb = 2'd3; end
            2:  begin sa = 1; sb = 2'd2; end
            3:  begin mr = 1; io = 1; end
            4:  begin wr = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin sa = 1; op = 2'd2; end
            7:  begin wr = 1; rd = 1; end
            8:  begin sa = 1; op = 2'd1; pwc = 1; ps = 2'd1; end
            9:  begin pw = 1; ps = 2'd2; end
            10: begin sa = 1; sb = 2'd2; end
            11: begin wr = 1; end
            default: ;
        endcase
        return {pw, pwc, ps, irw, io, mr, mw, rr, wr, rd, m2r, sa, sb, op};
    endfunction

    // driver: one clock cycle with the given inputs, then check the outputs
    task automatic step(input logic [3:0] exp_st, input logic rdy, input logic [5:0] op);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = rdy;
        opcode    = op;
        funct     = 6'($urandom_range(0, 63));
        #1;
        check("state", state_dbg, exp_st);
        check("ctrl", obs, exp_ctrl(int'(exp_st), rdy));
        check("fault", fault, exp_st == 4'd15);
    endtask

    task automatic push(input logic [3:0] st, input logic rdy);
        exp_q.push_back(st);
        rdy_q.push_back(rdy);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected state visits and replay it.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        bit first = 1;
        for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        push(4'd1, rnd_bit());
        case (op)
            6'h00: begin push(4'd6, rnd_bit()); push(4'd7, rnd_bit()); end
            6'h23: begin
                push(4'd2, rnd_bit());
                for (int i = 0; i < mw; i++) push(4'd3, 1'b0);
                push(4'd3, 1'b1);
                push(4'd4, rnd_bit());
            end
            6'h2B: begin
                push(4'd2, rnd_bit());
                for (int i = 0; i < mw; i++) push(4'd5, 1'b0);
                push(4'd5, 1'b1);
            end
            6'h04: push(4'd8, rnd_bit());
            6'h02: push(4'd9, rnd_bit());
            6'h08: begin push(4'd10, rnd_bit()); push(4'd11, rnd_bit()); end
            default: ;  // NOP: fetch and decode only
        endcase
        while (exp_q.size() > 0) begin
            logic [3:0] st;
            logic       r;
            st = exp_q.pop_front();
            r  = rdy_q.pop_front();
            step(st, r, op);
            if (first) check("retired", retired, model_retired);
            first = 0;
        end
        model_retired = model_retired + 32'd1;
    endtask

    function automatic int rnd_wait();
        if ($urandom_range(0, 7) == 0) return 15;  // longest stall without fault
        return int'($urandom_range(0, 3));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = rnd_bit();
        #1;
        model_retired = 32'd0;
    endtask

    initial begin
        logic [5:0] ops[6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", state_dbg, 4'd0);
        check("rst_ctrl", obs, exp_ctrl(0, 1'b0));
        check("rst_retired", retired, 32'd0);
        check("rst_fault", fault, 1'b0);

        // directed: addi, lw with 3 stalls, then R, sw, beq, j
        run_instr(6'h08, 0, 0);
        run_instr(6'h23, 0, 3);
        run_instr(6'h00, 0, 0);
        run_instr(6'h2B, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
        run_instr(6'h3F, 0, 0);
`endif

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            int         pick;
            logic [5:0] op;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            pick = int'($urandom_range(0, 5));
`else
            pick = int'($urandom_range(0, 6));
`endif
            if (pick < 6) begin
                op = ops[pick];
            end else begin
                op = 6'($urandom_range(0, 63));
                while (op == 6'h00 || op == 6'h02 || op == 6'h04 ||
                       op == 6'h08 || op == 6'h23 || op == 6'h2B)
                    op = 6'($urandom_range(0, 63));
            end
            run_instr(op, rnd_wait(), rnd_wait());
        end

        // reset in the middle of a stalled store
        step(4'd0, 1'b1, 6'h2B);
        check("retired_run", retired, model_retired);
        step(4'd1, 1'b0, 6'h2B);
        step(4'd2, 1'b0, 6'h2B);
        step(4'd5, 1'b0, 6'h2B);
        step(4'd5, 1'b0, 6'h2B);
        do_reset();
        step(4'd0, 1'b0, 6'h2B);
        check("rst_mid_mem_write", mem_write, 1'b0);
        check("rst_mid_retired", retired, 32'd0);
        check("rst_mid_fault", fault, 1'b0);

        // fetch timeout: 16 stalled cycles, then FAULT until reset
        run_instr(6'h08, 2, 0);
        for (int i = 0; i < 15; i++) step(4'd0, 1'b0, 6'h08);
        step(4'd0, 1'b0, 6'h08);
        for (int i = 0; i < 5; i++) step(4'd15, rnd_bit(), 6'h08);
        check("fault_retired", retired, model_retired);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        check("timeout_not_illegal", illegal, 1'b0);
`endif
        do_reset();
        step(4'd0, 1'b0, 6'h08);
        check("post_fault_clear", fault, 1'b0);

        // load stalled for the full timeout inside MEM_RD
        step(4'd0, 1'b1, 6'h23);
        step(4'd1, 1'b1, 6'h23);
        step(4'd2, 1'b1, 6'h23);
        for (int i = 0; i < 16; i++) step(4'd3, 1'b0, 6'h23);
        step(4'd15, 1'b1, 6'h23);
        check("memrd_timeout_retired", retired, 32'd0);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        // unknown opcode traps instead of retiring
        do_reset();
        run_instr(6'h08, 0, 0);
        step(4'd0, 1'b1, 6'h3F);
        step(4'd1, 1'b0, 6'h3F);
        step(4'd15, 1'b1, 6'h3F);
        check("illegal_flag", illegal, 1'b1);
        check("illegal_retired", retired, model_retired);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
